alu_data_inst_memory: RTL and testbench

// - Execution/storage block of the UART-loaded core: instruction ROM loaded byte-wise, data RAM and R-type ALU.
// - Core controller drives pc, loader bytes, memory strobes and ALU decode fields; ALU owns the 32x32 register file.
// - Instruction store, data store and ALU are independent sub-blocks sharing CLK/RST_N.

---
 rtl/alu_data_inst_memory_if.sv | 48 ++++
 rtl/alu_data_inst_memory.sv | 141 ++++++++++++++
 tb/tb_alu_data_inst_memory.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_data_inst_memory_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_data_inst_memory_if
// Brief    : Controller-facing bus of the execution/storage block (loader,
//            data store and ALU decode fields).
// Revision : 1.0 - initial release
// ============================================================================
interface alu_data_inst_memory_if #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int DATA_MEM_WIDTH = 8
);
  logic [INST_MEM_WIDTH-1:0] pc;
  logic [7:0]                loader_data;
  logic                      loader_enable;
  logic                      loader_ready;
  logic [31:0]               inst;

  logic [31:0]               write_data;
  logic                      write_enable;
  logic                      write_ready;
  logic [DATA_MEM_WIDTH-1:0] write_index;
  logic [31:0]               read_data;
  logic                      read_enable;
  logic [DATA_MEM_WIDTH-1:0] read_index;

  logic [5:0]                funct;
  logic                      alu_enable;
  logic [4:0]                rs;
  logic [4:0]                rt;
  logic [4:0]                sa;
  logic [4:0]                rd;
  logic                      alu_valid;

  modport master (
    output pc, loader_data, loader_enable, loader_ready,
    output write_data, write_enable, write_index, read_enable, read_index,
    output funct, alu_enable, rs, rt, sa, rd,
    input  inst, write_ready, read_data, alu_valid
  );

  modport slave (
    input  pc, loader_data, loader_enable, loader_ready,
    input  write_data, write_enable, write_index, read_enable, read_index,
    input  funct, alu_enable, rs, rt, sa, rd,
    output inst, write_ready, read_data, alu_valid
  );
endinterface
`default_nettype wire

// File: rtl/alu_data_inst_memory.sv
`default_nettype none
// ============================================================================
// Module   : alu_data_inst_memory
// Brief    : Byte-loaded instruction ROM, 32-bit data RAM and R-type ALU with
//            its 32x32 register file. Optional: ALU_MUL_EN adds funct 0x18 MUL.
// Revision : 1.0 - initial release
// ============================================================================
module alu_data_inst_memory #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int DATA_MEM_WIDTH = 8
) (
  input wire                    CLK,
  input wire                    RST_N,
  alu_data_inst_memory_if.slave bus
);
  localparam int c_INST_DEPTH = 2 ** INST_MEM_WIDTH;
  localparam int c_DATA_DEPTH = 2 ** DATA_MEM_WIDTH;

  localparam logic [5:0] c_FN_SLL = 6'h00;
  localparam logic [5:0] c_FN_SRL = 6'h02;
  localparam logic [5:0] c_FN_ADD = 6'h20;
  localparam logic [5:0] c_FN_SUB = 6'h22;
  localparam logic [5:0] c_FN_AND = 6'h24;
  localparam logic [5:0] c_FN_OR  = 6'h25;
  localparam logic [5:0] c_FN_NOR = 6'h27;
  localparam logic [5:0] c_FN_SLT = 6'h2A;
`ifdef ALU_MUL_EN
  localparam logic [5:0] c_FN_MUL = 6'h18;
`endif

  // ---------------------------------------------------------------- loader
  logic [31:0]               r_imem [c_INST_DEPTH];
  logic [INST_MEM_WIDTH-1:0] r_ptr;
  logic [1:0]                r_byte_cnt;
  logic [23:0]               r_byte_buf;
  logic                      r_loader_en_d;
  logic                      w_load_start;
  logic [1:0]                w_byte_idx;
  logic [INST_MEM_WIDTH-1:0] w_ptr;

  assign bus.inst = r_imem[bus.pc];

  // A byte arriving on the same edge as the enable rising edge is byte 0 of word 0.
  assign w_load_start = bus.loader_enable & ~r_loader_en_d;
  assign w_byte_idx   = w_load_start ? 2'd0 : r_byte_cnt;
  assign w_ptr        = w_load_start ? '0 : r_ptr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < c_INST_DEPTH; i++) r_imem[i] <= '0;
      r_ptr         <= '0;
      r_byte_cnt    <= '0;
      r_byte_buf    <= '0;
      r_loader_en_d <= 1'b0;
    end else begin
      r_loader_en_d <= bus.loader_enable;
      if (!bus.loader_enable) begin
        r_byte_cnt <= '0;
      end else if (bus.loader_ready) begin
        r_byte_cnt <= w_byte_idx + 2'd1;
        case (w_byte_idx)
          2'd0: begin r_byte_buf[7:0]   <= bus.loader_data; r_ptr <= w_ptr; end
          2'd1: begin r_byte_buf[15:8]  <= bus.loader_data; r_ptr <= w_ptr; end
          2'd2: begin r_byte_buf[23:16] <= bus.loader_data; r_ptr <= w_ptr; end
          default: begin
            r_imem[w_ptr] <= {bus.loader_data, r_byte_buf};
            r_ptr         <= w_ptr + 1'b1;
          end
        endcase
      end else if (w_load_start) begin
        r_byte_cnt <= '0;
        r_ptr      <= '0;
      end
    end
  end

  // ------------------------------------------------------------ data store
  logic [31:0] r_dmem [c_DATA_DEPTH];
  logic        r_write_ready;
  logic [31:0] r_read_data;

  assign bus.write_ready = r_write_ready;
  assign bus.read_data   = r_read_data;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < c_DATA_DEPTH; i++) r_dmem[i] <= '0;
      r_write_ready <= 1'b0;
      r_read_data   <= '0;
    end else begin
      // One write per request: write_ready blocks repeats while the level is held.
      if (bus.write_enable && !r_write_ready) r_dmem[bus.write_index] <= bus.write_data;
      r_write_ready <= bus.write_enable;
      if (bus.read_enable) r_read_data <= r_dmem[bus.read_index];
    end
  end

  // ------------------------------------------------------------------- ALU
  logic [31:0] r_regs [32];
  logic        r_alu_valid;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic [31:0] w_result;
  logic        w_result_ok;

  assign bus.alu_valid = r_alu_valid;
  assign w_op_a        = r_regs[bus.rs];
  assign w_op_b        = r_regs[bus.rt];

  always_comb begin
    w_result    = '0;
    w_result_ok = 1'b1;
    case (bus.funct)
      c_FN_ADD: w_result = w_op_a + w_op_b;
      c_FN_SUB: w_result = w_op_a - w_op_b;
      c_FN_AND: w_result = w_op_a & w_op_b;
      c_FN_OR:  w_result = w_op_a | w_op_b;
      c_FN_NOR: w_result = ~(w_op_a | w_op_b);
      c_FN_SLT: w_result = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
      c_FN_SLL: w_result = w_op_b << bus.sa;
      c_FN_SRL: w_result = w_op_b >> bus.sa;
`ifdef ALU_MUL_EN
      // Low word of the product is the same for signed and unsigned operands.
      c_FN_MUL: w_result = w_op_a * w_op_b;
`endif
      default:  w_result_ok = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      r_alu_valid <= 1'b0;
    end else begin
      r_alu_valid <= bus.alu_enable;
      // r0 is never written, so it reads as zero without a read-side mux.
      if (bus.alu_enable && w_result_ok && (bus.rd != 5'd0)) r_regs[bus.rd] <= w_result;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_alu_data_inst_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_data_inst_memory
// Brief    : Directed bench with a behavioural reference model and per-cycle compare.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_data_inst_memory;
  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_data_inst_memory_if #(.INST_MEM_WIDTH(2), .DATA_MEM_WIDTH(8)) bus ();
  alu_data_inst_memory #(.INST_MEM_WIDTH(2), .DATA_MEM_WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------ reference model
  logic [31:0] m_imem [4];
  logic [31:0] m_dmem [256];
  logic [31:0] m_regs [32];
  logic [7:0]  m_bytes [3];
  int          m_cnt, m_ptr, m_slot, m_wptr;
  logic        m_le_prev, m_start, m_wr, m_av;
  logic [31:0] m_rd;
  logic [32:0] m_alu;

  function automatic logic [32:0] alu_ref(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sa);
`ifdef ALU_MUL_EN
    longint p;
`endif
    case (f)
      6'h20: return {1'b1, a + b};
      6'h22: return {1'b1, a - b};
      6'h24: return {1'b1, a & b};
      6'h25: return {1'b1, a | b};
      6'h27: return {1'b1, ~(a | b)};
      6'h2A: return {1'b1, (int'(a) < int'(b)) ? 32'd1 : 32'd0};
      6'h00: return {1'b1, b << sa};
      6'h02: return {1'b1, b >> sa};
`ifdef ALU_MUL_EN
      6'h18: begin
        p = longint'(int'(a)) * longint'(int'(b));
        return {1'b1, p[31:0]};
      end
`endif
      default: return {1'b0, 32'd0};
    endcase
  endfunction

  always_comb begin
    m_start = bus.loader_enable && !m_le_prev;
    m_slot  = m_start ? 0 : m_cnt;
    m_wptr  = m_start ? 0 : m_ptr;
    m_alu   = alu_ref(bus.funct, m_regs[bus.rs], m_regs[bus.rt], bus.sa);
  end

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++) m_imem[i] <= '0;
      for (int i = 0; i < 256; i++) m_dmem[i] <= '0;
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_cnt <= 0; m_ptr <= 0; m_le_prev <= 1'b0;
      m_wr <= 1'b0; m_av <= 1'b0; m_rd <= '0;
    end else begin
      m_le_prev <= bus.loader_enable;
      if (bus.loader_enable && bus.loader_ready) begin
        if (m_slot == 3) begin
          m_imem[m_wptr] <= {bus.loader_data, m_bytes[2], m_bytes[1], m_bytes[0]};
          m_ptr <= (m_wptr + 1) % 4;
          m_cnt <= 0;
        end else begin
          m_bytes[m_slot] <= bus.loader_data;
          m_cnt <= m_slot + 1;
          m_ptr <= m_wptr;
        end
      end else if (!bus.loader_enable || m_start) begin
        m_cnt <= 0;
        if (m_start) m_ptr <= 0;
      end
      if (bus.write_enable && !m_wr) m_dmem[bus.write_index] <= bus.write_data;
      m_wr <= bus.write_enable;
      if (bus.read_enable) m_rd <= m_dmem[bus.read_index];
      m_av <= bus.alu_enable;
      if (bus.alu_enable && m_alu[32] && bus.rd != 5'd0) m_regs[bus.rd] <= m_alu[31:0];
    end
  end

  task automatic check_regs();
    int bad = -1;
    for (int i = 0; i < 32; i++)
      if (bad < 0 && dut.r_regs[i] !== m_regs[i]) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL regfile r%0d: got %08h expected %08h at %0t",
               bad, dut.r_regs[bad], m_regs[bad], $time);
    end
  endtask

  always @(negedge CLK) begin
    check32("inst", bus.inst, m_imem[bus.pc]);
    check32("read_data", bus.read_data, m_rd);
    check32("write_ready", {31'd0, bus.write_ready}, {31'd0, m_wr});
    check32("alu_valid", {31'd0, bus.alu_valid}, {31'd0, m_av});
    check_regs();
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    bus.loader_data  = b;
    bus.loader_ready = 1'b1;
    tick();
    bus.loader_ready = 1'b0;
    tick();
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) load_byte(w[8*k +: 8]);
  endtask

  task automatic alu_issue(input logic [5:0] f, input logic [4:0] s, input logic [4:0] t,
                           input logic [4:0] d, input logic [4:0] a);
    bus.funct = f; bus.rs = s; bus.rt = t; bus.rd = d; bus.sa = a;
    bus.alu_enable = 1'b1;
    tick();
  endtask

  task automatic inst_at(input logic [1:0] p, input logic [31:0] exp, input string name);
    bus.pc = p;
    #1;
    check32(name, bus.inst, exp);
  endtask

  logic [7:0] first_bytes [12];

  initial begin
    first_bytes = '{8'h00, 8'h00, 8'h00, 8'hEC, 8'h00, 8'h00, 8'h00, 8'hF0,
                    8'h02, 8'h00, 8'h00, 8'h20};
    bus.pc = '0; bus.loader_data = '0; bus.loader_enable = 1'b0; bus.loader_ready = 1'b0;
    bus.write_data = '0; bus.write_enable = 1'b0; bus.write_index = '0;
    bus.read_enable = 1'b0; bus.read_index = '0;
    bus.funct = '0; bus.alu_enable = 1'b0; bus.rs = '0; bus.rt = '0; bus.sa = '0; bus.rd = '0;
    repeat (3) tick();
    RST_N = 1'b1;
    tick();
    check32("reset inst", bus.inst, 32'h0);
    check32("reset read_data", bus.read_data, 32'h0);
    check32("reset write_ready", {31'd0, bus.write_ready}, 32'h0);
    check32("reset alu_valid", {31'd0, bus.alu_valid}, 32'h0);

    // Byte-wise load of three words, little-endian byte order within a word
    bus.loader_enable = 1'b1;
    for (int i = 0; i < 12; i++) load_byte(first_bytes[i]);
    bus.loader_enable = 1'b0;
    tick();
    inst_at(2'd0, 32'hEC000000, "load pc0");
    inst_at(2'd1, 32'hF0000000, "load pc1");
    inst_at(2'd2, 32'h20000002, "load pc2");
    repeat (4) load_byte(8'hAA);
    inst_at(2'd3, 32'h0, "ready ignored when disabled");

    // Five words into four slots: the fifth overwrites slot 0
    bus.loader_enable = 1'b1;
    for (int i = 1; i <= 5; i++) load_word(32'h11111111 * i);
    bus.loader_enable = 1'b0;
    tick();
    inst_at(2'd0, 32'h55555555, "wrap pc0");
    inst_at(2'd1, 32'h22222222, "wrap pc1");
    inst_at(2'd3, 32'h44444444, "wrap pc3");
    bus.loader_enable = 1'b1;
    repeat (3) load_byte(8'h99);
    bus.loader_enable = 1'b0;
    tick();
    inst_at(2'd0, 32'h55555555, "partial discarded");

    // Data store write handshake and read latency
    bus.write_index = 8'd5; bus.write_data = 32'hDEADBEEF; bus.write_enable = 1'b1;
    tick();
    check32("write_ready after write", {31'd0, bus.write_ready}, 32'h1);
    bus.write_data = 32'h12345678;
    tick();
    check32("write_ready held", {31'd0, bus.write_ready}, 32'h1);
    bus.write_enable = 1'b0;
    tick();
    check32("write_ready cleared", {31'd0, bus.write_ready}, 32'h0);
    bus.read_index = 8'd5; bus.read_enable = 1'b1;
    tick();
    check32("read @5", bus.read_data, 32'hDEADBEEF);
    bus.read_enable = 1'b0;
    tick();
    check32("read_data holds", bus.read_data, 32'hDEADBEEF);
    bus.write_data = 32'hCAFEF00D; bus.write_enable = 1'b1; bus.read_enable = 1'b1;
    tick();
    check32("read during write old word", bus.read_data, 32'hDEADBEEF);
    bus.write_enable = 1'b0;
    tick();
    check32("read after write new word", bus.read_data, 32'hCAFEF00D);
    bus.read_enable = 1'b0;
    tick();

    // ALU: build r1=5, r2=7 from an all-zero file, back-to-back
    alu_issue(6'h27, 5'd0, 5'd0, 5'd10, 5'd0);   // r10 = ~0
    check32("alu_valid pulse", {31'd0, bus.alu_valid}, 32'h1);
    alu_issue(6'h22, 5'd0, 5'd10, 5'd1, 5'd0);   // r1 = 1
    alu_issue(6'h00, 5'd0, 5'd1, 5'd2, 5'd1);    // r2 = 2
    alu_issue(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);    // r3 = 3
    alu_issue(6'h00, 5'd0, 5'd1, 5'd4, 5'd2);    // r4 = 4
    alu_issue(6'h20, 5'd1, 5'd4, 5'd1, 5'd0);    // r1 = 5
    alu_issue(6'h20, 5'd3, 5'd4, 5'd2, 5'd0);    // r2 = 7
    bus.alu_enable = 1'b0;
    tick();
    check32("alu_valid single pulse", {31'd0, bus.alu_valid}, 32'h0);
    check32("r1", dut.r_regs[1], 32'd5);
    check32("r2", dut.r_regs[2], 32'd7);
    alu_issue(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);    // ADD
    alu_issue(6'h22, 5'd1, 5'd2, 5'd5, 5'd0);    // SUB
    alu_issue(6'h2A, 5'd1, 5'd2, 5'd6, 5'd0);    // SLT 5<7
    alu_issue(6'h2A, 5'd5, 5'd1, 5'd7, 5'd0);    // SLT -2<5
    alu_issue(6'h2A, 5'd1, 5'd5, 5'd8, 5'd0);    // SLT 5<-2
    alu_issue(6'h24, 5'd1, 5'd2, 5'd9, 5'd0);    // AND
    alu_issue(6'h25, 5'd4, 5'd2, 5'd11, 5'd0);   // OR
    alu_issue(6'h00, 5'd0, 5'd1, 5'd13, 5'd31);  // SLL
    alu_issue(6'h02, 5'd0, 5'd10, 5'd14, 5'd4);  // SRL
    alu_issue(6'h20, 5'd1, 5'd2, 5'd0, 5'd0);    // write to r0
    alu_issue(6'h3F, 5'd1, 5'd2, 5'd15, 5'd0);   // unknown funct
    check32("alu_valid unknown funct", {31'd0, bus.alu_valid}, 32'h1);
    alu_issue(6'h18, 5'd5, 5'd1, 5'd16, 5'd0);   // MUL (optional)
    bus.alu_enable = 1'b0;
    tick();
    check32("ADD r3", dut.r_regs[3], 32'd12);
    check32("SUB r5", dut.r_regs[5], 32'hFFFFFFFE);
    check32("SLT r6", dut.r_regs[6], 32'd1);
    check32("SLT r7", dut.r_regs[7], 32'd1);
    check32("SLT r8", dut.r_regs[8], 32'd0);
    check32("AND r9", dut.r_regs[9], 32'd5);
    check32("OR r11", dut.r_regs[11], 32'd7);
    check32("SLL r13", dut.r_regs[13], 32'h80000000);
    check32("SRL r14", dut.r_regs[14], 32'h0FFFFFFF);
    check32("r0 stays zero", dut.r_regs[0], 32'd0);
    check32("unknown no write", dut.r_regs[15], 32'd0);
`ifdef ALU_MUL_EN
    check32("MUL r16", dut.r_regs[16], 32'hFFFFFFF6);
`else
    check32("MUL disabled r16", dut.r_regs[16], 32'd0);
`endif

    // Reset in the middle of a load, a write and an ALU op
    bus.loader_enable = 1'b1;
    load_byte(8'h77);
    load_byte(8'h88);
    bus.write_index = 8'd7; bus.write_data = 32'h0BADF00D; bus.write_enable = 1'b1;
    alu_issue(6'h20, 5'd1, 5'd2, 5'd20, 5'd0);
    RST_N = 1'b0;
    #1;
    check32("mid reset write_ready", {31'd0, bus.write_ready}, 32'h0);
    check32("mid reset alu_valid", {31'd0, bus.alu_valid}, 32'h0);
    check32("mid reset regs", dut.r_regs[3], 32'h0);
    inst_at(2'd2, 32'h0, "mid reset imem");
    bus.loader_enable = 1'b0; bus.write_enable = 1'b0; bus.alu_enable = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    bus.read_index = 8'd7; bus.read_enable = 1'b1;
    tick();
    check32("dmem cleared", bus.read_data, 32'h0);
    bus.read_enable = 1'b0;
    bus.loader_enable = 1'b1;
    load_word(32'hA5A5A5A5);
    bus.loader_enable = 1'b0;
    tick();
    inst_at(2'd0, 32'hA5A5A5A5, "ptr restarts at 0");
    inst_at(2'd1, 32'h0, "slot1 cleared");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
